// File: rtl/edit_btn_pkg.sv
// Shared types and default timing constants for the edit-button conditioner.
// EDIT_BTN_AUTO_REPEAT_EN adds the REPEAT channel state.
package edit_btn_pkg;

   localparam int unsigned DEF_DEBOUNCE_CYCLES     = 2_000_000;
   localparam int unsigned DEF_REPEAT_DELAY_CYCLES = 50_000_000;
   localparam int unsigned DEF_REPEAT_RATE_CYCLES  = 20_000_000;
   localparam int unsigned NUM_BTNS                = 2;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_PRESS_DB   = 3'd1,
      ST_HELD       = 3'd2,
      ST_RELEASE_DB = 3'd3
`ifdef EDIT_BTN_AUTO_REPEAT_EN
      ,
      ST_REPEAT     = 3'd4
`endif
   } chan_state_e;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // One spare bit above the largest threshold so saturation never aliases a compare.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      return $clog2(max3(a, b, c)) + 1;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce/hold FSM and shared counter.
// EDIT_BTN_AUTO_REPEAT_EN enables the HELD->REPEAT auto-repeat path.
module btn_channel
   import edit_btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
   parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic raw_i,
   output logic pulse_o,
   output logic level_o
);

   localparam int unsigned CNT_W =
      cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
`ifdef EDIT_BTN_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);
`endif

   logic [1:0]       sync_q;
   logic             sync;
   chan_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             pulse_q, pulse_d;
   logic             level_q, level_d;
`ifdef EDIT_BTN_AUTO_REPEAT_EN
   logic             rpt_q, rpt_d;
`endif

   assign sync    = sync_q[1];
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
   assign pulse_o = pulse_q;
   assign level_o = level_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q  <= 2'b00;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
`ifdef EDIT_BTN_AUTO_REPEAT_EN
         rpt_q   <= 1'b0;
`endif
      end else begin
         sync_q  <= {sync_q[0], raw_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         level_q <= level_d;
`ifdef EDIT_BTN_AUTO_REPEAT_EN
         rpt_q   <= rpt_d;
`endif
      end
   end

   // Next state; counter holds the run length of the current sync level or hold time.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      level_d = level_q;
`ifdef EDIT_BTN_AUTO_REPEAT_EN
      rpt_d   = rpt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            level_d = 1'b0;
            if (sync) begin
               if (DEBOUNCE_CYCLES == 32'd1) begin
                  state_d = ST_HELD;
                  cnt_d   = '0;
                  pulse_d = 1'b1;
                  level_d = 1'b1;
`ifdef EDIT_BTN_AUTO_REPEAT_EN
                  rpt_d   = 1'b0;
`endif
               end else begin
                  state_d = ST_PRESS_DB;
                  cnt_d   = CNT_ONE;
               end
            end
         end

         ST_PRESS_DB: begin
            if (!sync) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q >= DB_LAST) begin
               state_d = ST_HELD;
               cnt_d   = '0;
               pulse_d = 1'b1;
               level_d = 1'b1;
`ifdef EDIT_BTN_AUTO_REPEAT_EN
               rpt_d   = 1'b0;
`endif
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_HELD: begin
            if (!sync) begin
               if (DEBOUNCE_CYCLES == 32'd1) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  level_d = 1'b0;
               end else begin
                  state_d = ST_RELEASE_DB;
                  cnt_d   = CNT_ONE;
               end
`ifdef EDIT_BTN_AUTO_REPEAT_EN
            end else if (cnt_q >= DELAY_LAST) begin
               state_d = ST_REPEAT;
               cnt_d   = '0;
               pulse_d = 1'b1;
               rpt_d   = 1'b1;
`endif
            end else begin
               cnt_d = cnt_inc;
            end
         end

`ifdef EDIT_BTN_AUTO_REPEAT_EN
         ST_REPEAT: begin
            if (!sync) begin
               if (DEBOUNCE_CYCLES == 32'd1) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  level_d = 1'b0;
               end else begin
                  state_d = ST_RELEASE_DB;
                  cnt_d   = CNT_ONE;
               end
            end else if (cnt_q >= RATE_LAST) begin
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
`endif

         ST_RELEASE_DB: begin
            if (sync) begin
`ifdef EDIT_BTN_AUTO_REPEAT_EN
               state_d = rpt_q ? ST_REPEAT : ST_HELD;
`else
               state_d = ST_HELD;
`endif
               cnt_d   = '0;
            end else if (cnt_q >= DB_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/edit_btn_cond.sv
// Conditions the two raw watch-edit buttons into debounced levels and edit pulses.
// EDIT_BTN_AUTO_REPEAT_EN adds auto-repeat pulses while a button is held.
module edit_btn_cond
   import edit_btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
   parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btns_raw,
   output logic [NUM_BTNS-1:0] edit_btns,
   output logic [NUM_BTNS-1:0] btns_level
);

   // Bit 0: minutes edit.
   btn_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
   ) u_min_chan (
      .clk_i   (clk),
      .reset_i (reset),
      .raw_i   (btns_raw[0]),
      .pulse_o (edit_btns[0]),
      .level_o (btns_level[0])
   );

   // Bit 1: hours edit.
   btn_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
   ) u_hour_chan (
      .clk_i   (clk),
      .reset_i (reset),
      .raw_i   (btns_raw[1]),
      .pulse_o (edit_btns[1]),
      .level_o (btns_level[1])
   );

endmodule

// File: tb/tb_edit_btn_cond.sv
// Scoreboard bench for edit_btn_cond with DEBOUNCE=4, DELAY=10, RATE=3.
// Expected pulse cycles follow the edge-counted timings of the button behaviour.
module tb_edit_btn_cond;

   localparam int unsigned DB    = 4;
   localparam int unsigned DELAY = 10;
   localparam int unsigned RATE  = 3;

   typedef struct {
      int         at;
      logic [1:0] val;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [1:0] btns_raw;
   logic [1:0] edit_btns;
   logic [1:0] btns_level;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   edit_btn_cond #(
      .DEBOUNCE_CYCLES     (DB),
      .REPEAT_DELAY_CYCLES (DELAY),
      .REPEAT_RATE_CYCLES  (RATE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btns_raw   (btns_raw),
      .edit_btns  (edit_btns),
      .btns_level (btns_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int at, input logic [1:0] val);
      exp_t e;
      e.at  = at;
      e.val = val;
      sb.push_back(e);
   endtask

   // Advance to the next falling edge and score edit_btns against the queue.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      if (sb.size() != 0 && sb[0].at < cyc) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL missed_pulse: expected edit_btns=%b at cycle %0d, not seen (now %0d)",
                  e.val, e.at, cyc);
      end
      checks++;
      if (sb.size() != 0 && sb[0].at == cyc) begin
         e = sb.pop_front();
         if (edit_btns !== e.val) begin
            errors++;
            $display("FAIL pulse_value: cycle %0d edit_btns=%b expected %b", cyc, edit_btns, e.val);
         end
      end else if (edit_btns !== 2'b00) begin
         errors++;
         $display("FAIL unexpected_pulse: cycle %0d edit_btns=%b expected 00", cyc, edit_btns);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      btns_raw = 2'b11;
      idle(3);
      btns_raw = 2'b00;
      idle(2);
      checks++;
      if (btns_level !== 2'b00) begin
         errors++;
         $display("FAIL reset_level: btns_level=%b expected 00", btns_level);
      end
      reset = 1'b0;
      idle(4);
      checks++;
      if (btns_level !== 2'b00) begin
         errors++;
         $display("FAIL post_reset_level: btns_level=%b expected 00", btns_level);
      end
   endtask

   task automatic test_press();
      int base;
      btns_raw = 2'b01;
      base     = cyc;
      push(base + 6, 2'b01);
      for (int i = 1; i <= 10; i++) begin
         cycle();
         checks++;
         if (btns_level[0] !== ((cyc - base) >= 6)) begin
            errors++;
            $display("FAIL press_level: cycle +%0d level=%b expected %b",
                     cyc - base, btns_level[0], (cyc - base) >= 6);
         end
      end
      btns_raw = 2'b00;
      base     = cyc;
      for (int i = 1; i <= 8; i++) begin
         cycle();
         checks++;
         if (btns_level[0] !== ((cyc - base) < 6)) begin
            errors++;
            $display("FAIL release_level: cycle +%0d level=%b expected %b",
                     cyc - base, btns_level[0], (cyc - base) < 6);
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL press_drain: %0d pulses outstanding expected 0", sb.size());
      end
   endtask

   task automatic test_bounce();
      logic [5:0] pat;
      pat = 6'b011011;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 6; i++) begin
            btns_raw = {1'b0, pat[5 - i]};
            cycle();
            checks++;
            if (btns_level !== 2'b00) begin
               errors++;
               $display("FAIL bounce_level: btns_level=%b expected 00", btns_level);
            end
         end
      end
      btns_raw = 2'b00;
      idle(8);
      checks++;
      if (btns_level !== 2'b00) begin
         errors++;
         $display("FAIL bounce_final_level: btns_level=%b expected 00", btns_level);
      end
   endtask

   task automatic test_both();
      int base;
      btns_raw = 2'b11;
      base     = cyc;
      push(base + 6, 2'b11);
      idle(8);
      checks++;
      if (btns_level !== 2'b11) begin
         errors++;
         $display("FAIL both_level: btns_level=%b expected 11", btns_level);
      end
      btns_raw = 2'b00;
      idle(8);
      checks++;
      if (btns_level !== 2'b00 || sb.size() != 0) begin
         errors++;
         $display("FAIL both_release: btns_level=%b pending=%0d expected 00/0", btns_level, sb.size());
      end
   endtask

   task automatic test_independent();
      int base;
      btns_raw = 2'b01;
      base     = cyc;
      push(base + 6, 2'b01);
      push(base + 8, 2'b10);
      idle(2);
      btns_raw = 2'b11;
      idle(8);
      checks++;
      if (btns_level !== 2'b11) begin
         errors++;
         $display("FAIL indep_level: btns_level=%b expected 11", btns_level);
      end
      btns_raw = 2'b00;
      idle(8);
      checks++;
      if (btns_level !== 2'b00 || sb.size() != 0) begin
         errors++;
         $display("FAIL indep_release: btns_level=%b pending=%0d expected 00/0", btns_level, sb.size());
      end
   endtask

   task automatic test_glitch();
      int base;
      btns_raw = 2'b01;
      base     = cyc;
      push(base + 6, 2'b01);
      idle(8);
      btns_raw = 2'b00;
      idle(2);
      btns_raw = 2'b01;
      for (int i = 0; i < 8; i++) begin
         cycle();
         checks++;
         if (btns_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_level: cycle +%0d level=%b expected 1", cyc - base, btns_level[0]);
         end
      end
      btns_raw = 2'b00;
      idle(8);
      checks++;
      if (btns_level !== 2'b00 || sb.size() != 0) begin
         errors++;
         $display("FAIL glitch_release: btns_level=%b pending=%0d expected 00/0", btns_level, sb.size());
      end
   endtask

   task automatic test_repeat();
      int base;
      btns_raw = 2'b01;
      base     = cyc;
      push(base + 6, 2'b01);
`ifdef EDIT_BTN_AUTO_REPEAT_EN
      push(base + 16, 2'b01);
      for (int k = 19; k <= 31; k += 3) push(base + k, 2'b01);
`endif
      idle(30);
      checks++;
      if (btns_level !== 2'b01) begin
         errors++;
         $display("FAIL repeat_level: btns_level=%b expected 01", btns_level);
      end
      btns_raw = 2'b00;
      idle(10);
      checks++;
      if (btns_level !== 2'b00 || sb.size() != 0) begin
         errors++;
         $display("FAIL repeat_release: btns_level=%b pending=%0d expected 00/0", btns_level, sb.size());
      end
   endtask

   task automatic test_reset_abort();
      int base;
      btns_raw = 2'b01;
      base     = cyc;
      idle(5);
      reset = 1'b1;
      cycle();
      checks++;
      if (btns_level !== 2'b00) begin
         errors++;
         $display("FAIL abort_level: btns_level=%b expected 00", btns_level);
      end
      reset = 1'b0;
      push(base + 12, 2'b01);
      idle(6);
      checks++;
      if (btns_level !== 2'b01) begin
         errors++;
         $display("FAIL abort_repress_level: btns_level=%b expected 01", btns_level);
      end
      btns_raw = 2'b00;
      idle(8);
      checks++;
      if (btns_level !== 2'b00 || sb.size() != 0) begin
         errors++;
         $display("FAIL abort_release: btns_level=%b pending=%0d expected 00/0", btns_level, sb.size());
      end
   endtask

   initial begin
      reset    = 1'b1;
      btns_raw = 2'b00;
      test_reset();
      test_press();
      test_bounce();
      test_both();
      test_independent();
      test_glitch();
      test_repeat();
      test_reset_abort();
      idle(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
